// File: rtl/trig_arbiter.sv
// Round-robin arbiter sharing one combinational trig_table between two requesters.
// Two-stage pipeline: stage 1 drives the table angle, stage 2 registers the looked-up result.
module trig_arbiter #(
  parameter int VALUE_WIDTH = 32,
  parameter int ANGLE_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req0_valid,
  input  logic [ANGLE_WIDTH-1:0]        req0_angle,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [ANGLE_WIDTH-1:0]        req1_angle,
  output logic                          req1_ready,
  output logic [ANGLE_WIDTH-1:0]        trig_angle,
  input  logic signed [VALUE_WIDTH-1:0] trig_sin,
  input  logic signed [VALUE_WIDTH-1:0] trig_cos,
  output logic                          rsp_valid,
  output logic                          rsp_id,
  output logic signed [VALUE_WIDTH-1:0] rsp_sin,
  output logic signed [VALUE_WIDTH-1:0] rsp_cos,
  input  logic                          rsp_ready
);

  logic                   s1_valid;
  logic                   s1_id;
  logic                   last_grant;

  logic                   stall;
  logic                   can_accept;
  logic                   accept;
  logic                   grant_id;
  logic [ANGLE_WIDTH-1:0] grant_angle;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    stall       = rsp_valid && !rsp_ready;
    // Readies are forced low while reset is asserted, not just after the first edge.
    can_accept  = rst_n && !(s1_valid && stall);

    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end

    accept      = can_accept && (req0_valid || req1_valid);
    grant_angle = grant_id ? req1_angle : req0_angle;
    req0_ready  = accept && !grant_id;
    req1_ready  = accept && grant_id;
  end

  // Stage 1: trig_angle only moves on an accepted transfer so the table output stays put on drain.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      trig_angle <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_id      <= grant_id;
      trig_angle <= grant_angle;
      last_grant <= grant_id;
    end else if (can_accept) begin
      s1_valid   <= 1'b0;
    end
  end

  // Stage 2: capture the table output for the angle held in stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sin   <= '0;
      rsp_cos   <= '0;
    end else if (s1_valid && !stall) begin
      rsp_valid <= 1'b1;
      rsp_id    <= s1_id;
      rsp_sin   <= trig_sin;
      rsp_cos   <= trig_cos;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
